// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with a two-entry skid buffer, registered in_ready and synchronous flush.
// Optional saturating performance counters are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_elastic #(
  parameter int                DATA_W     = 16,
  parameter int                CTRL_W     = 8,
  parameter logic [CTRL_W-1:0] CTRL_NOP   = {CTRL_W{1'b0}},
  parameter bit                CLEAR_DATA = 1'b0
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,parameter int               CNT_W      = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,output logic [CNT_W-1:0] stall_cycles
  ,output logic [CNT_W-1:0] bubble_cycles
  ,output logic [CNT_W-1:0] flush_count
`endif
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and storage update; flush overrides every handshake transition.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = CTRL_NOP;
      skid_ctrl_d = CTRL_NOP;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end else begin
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = ST_FULL;
          end else if (out_fire) begin
            main_ctrl_d = CTRL_NOP;
            state_d     = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = CTRL_NOP;
          skid_ctrl_d = CTRL_NOP;
        end
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Stage storage and handshake flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_NOP;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_NOP;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d, flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_d     = stall_q;
    bubble_d    = bubble_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
    if (!out_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end else begin
      bubble_d = bubble_q;
    end
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q     <= '0;
      bubble_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_q     <= stall_d;
      bubble_q    <= bubble_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
  assign flush_count   = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (counter test active with PIPE_STAGE_PERF_CNT_EN).
module tb_pipe_stage_elastic;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [3:0]  stall_cycles, bubble_cycles, flush_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_elastic #(
    .DATA_W(16), .CTRL_W(8), .CTRL_NOP(8'h00), .CLEAR_DATA(1'b0)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,.CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,.stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles), .flush_count(flush_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_ctrl = 8'h00; out_ready = 1'b0;
    repeat (2) tick();
    n_vec++;
    if ({in_ready, out_valid, occupancy, out_ctrl, out_data} !== {1'b1, 1'b0, 2'd0, 8'h00, 16'h0000}) begin
      n_err++;
      $display("FAIL reset: got rdy=%b vld=%b occ=%0d ctrl=%h data=%h, expected rdy=1 vld=0 occ=0 ctrl=00 data=0000",
               in_ready, out_valid, occupancy, out_ctrl, out_data);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_data = 16'(i); in_ctrl = 8'hA0 | 8'(i);
      tick();
      n_vec++;
      if ({in_ready, out_valid, occupancy, out_data, out_ctrl} !== {1'b1, 1'b1, 2'd1, 16'(i), 8'hA0 | 8'(i)}) begin
        n_err++;
        $display("FAIL stream[%0d]: got rdy=%b vld=%b occ=%0d data=%h ctrl=%h, expected rdy=1 vld=1 occ=1 data=%h ctrl=%h",
                 i, in_ready, out_valid, occupancy, out_data, out_ctrl, 16'(i), 8'hA0 | 8'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if ({out_valid, occupancy, out_ctrl} !== {1'b0, 2'd0, 8'h00}) begin
      n_err++;
      $display("FAIL stream_drain: got vld=%b occ=%0d ctrl=%h, expected vld=0 occ=0 ctrl=00", out_valid, occupancy, out_ctrl);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h01;
    for (int k = 0; k < 5; k++) begin
      in_data = (k == 0) ? 16'h0021 : (k == 1) ? 16'h0022 : 16'h0023;
      tick();
      n_vec++;
      if ({in_ready, occupancy, out_valid, out_data} !== {1'(k == 0), (k == 0) ? 2'd1 : 2'd2, 1'b1, 16'h0021}) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got rdy=%b occ=%0d vld=%b data=%h, expected rdy=%b occ=%0d vld=1 data=0021",
                 k, in_ready, occupancy, out_valid, out_data, (k == 0), (k == 0) ? 1 : 2);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_vec++;
    if ({in_ready, occupancy, out_valid, out_data} !== {1'b1, 2'd1, 1'b1, 16'h0022}) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b occ=%0d vld=%b data=%h, expected rdy=1 occ=1 vld=1 data=0022",
               in_ready, occupancy, out_valid, out_data);
    end
    tick();
    n_vec++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL bp_empty: got vld=%b occ=%0d, expected vld=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h0031; in_ctrl = 8'h11; tick();
    in_data = 16'h0032; in_ctrl = 8'h12; tick();
    n_vec++;
    if ({occupancy, in_ready} !== {2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL flush_fill: got occ=%0d rdy=%b, expected occ=2 rdy=0", occupancy, in_ready);
    end
    flush = 1'b1; in_data = 16'h0033; in_ctrl = 8'h13;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_ctrl, occupancy, out_data, in_ready} !== {1'b0, 8'h00, 2'd0, 16'h0031, 1'b1}) begin
      n_err++;
      $display("FAIL flush_full: got vld=%b ctrl=%h occ=%0d data=%h rdy=%b, expected vld=0 ctrl=00 occ=0 data=0031 rdy=1",
               out_valid, out_ctrl, occupancy, out_data, in_ready);
    end
    tick();
    n_vec++;
    if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL flush_dropped: got vld=%b occ=%0d, expected vld=0 occ=0", out_valid, occupancy);
    end
    in_valid = 1'b1; in_data = 16'h0034; in_ctrl = 8'h14;
    tick();
    flush = 1'b1; in_data = 16'h0035; in_ctrl = 8'h15; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++;
    if ({out_valid, occupancy, out_data, out_ctrl} !== {1'b0, 2'd0, 16'h0034, 8'h00}) begin
      n_err++;
      $display("FAIL flush_one_fire: got vld=%b occ=%0d data=%h ctrl=%h, expected vld=0 occ=0 data=0034 ctrl=00",
               out_valid, occupancy, out_data, out_ctrl);
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0040; in_ctrl = 8'h20;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'h0040 + 16'(i);
      tick();
      n_vec++;
      if ({occupancy, out_valid, out_data, in_ready} !== {2'd1, 1'b1, 16'h0040 + 16'(i), 1'b1}) begin
        n_err++;
        $display("FAIL simul[%0d]: got occ=%0d vld=%b data=%h rdy=%b, expected occ=1 vld=1 data=%h rdy=1",
                 i, occupancy, out_valid, out_data, in_ready, 16'h0040 + 16'(i));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h0055; in_ctrl = 8'h5A;
    tick();
    n_vec++;
    if ({out_valid, out_data, out_ctrl} !== {1'b1, 16'h0055, 8'h5A}) begin
      n_err++;
      $display("FAIL areset_pre: got vld=%b data=%h ctrl=%h, expected vld=1 data=0055 ctrl=5a", out_valid, out_data, out_ctrl);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready, out_ctrl, occupancy, out_data} !== {1'b0, 1'b1, 8'h00, 2'd0, 16'h0000}) begin
      n_err++;
      $display("FAIL areset: got vld=%b rdy=%b ctrl=%h occ=%0d data=%h, expected vld=0 rdy=1 ctrl=00 occ=0 data=0000",
               out_valid, in_ready, out_ctrl, occupancy, out_data);
    end
    tick();
    in_valid = 1'b0;
    reset_n = 1'b1;
  endtask

`ifdef PIPE_STAGE_PERF_CNT_EN
  task automatic test_counters();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick();
    n_vec++;
    if ({stall_cycles, bubble_cycles, flush_count} !== 12'h000) begin
      n_err++;
      $display("FAIL cnt_reset: got stall=%h bubble=%h flush=%h, expected 0 0 0", stall_cycles, bubble_cycles, flush_count);
    end
    reset_n = 1'b1; in_valid = 1'b1; in_data = 16'h0066; in_ctrl = 8'h66;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    n_vec++;
    if ({stall_cycles, bubble_cycles} !== {4'hF, 4'h1}) begin
      n_err++;
      $display("FAIL cnt_stall_sat: got stall=%h bubble=%h, expected stall=f bubble=1", stall_cycles, bubble_cycles);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({flush_count, occupancy} !== {4'h1, 2'd0}) begin
      n_err++;
      $display("FAIL cnt_flush: got flush_count=%h occ=%0d, expected 1 0", flush_count, occupancy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_simultaneous();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_CNT_EN
    test_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
